// File: rtl/linear_layer_start_fifo_ctrl.sv
// Start-token FIFO control for a shift-register store; a token is visible one cycle after its push, with no bypass.
// Backpressure comes from the registered if_full_n/if_empty_n flags; define START_FIFO_STATUS_EN to add usedw/err_sticky.
module linear_layer_start_fifo_ctrl #(
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic                  sr_we,
`ifdef START_FIFO_STATUS_EN
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  err_sticky,
`endif
  output logic [ADDR_WIDTH-1:0] sr_addr
);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  push;
  logic                  pop;
  logic                  empty_n_nxt;
  logic                  full_n_nxt;
  logic [ADDR_WIDTH-1:0] sr_addr_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:   if (push) state_nxt = S_PARTIAL;
      S_PARTIAL: begin
        if (push && !pop && cnt == DEPTH_C - ONE)  state_nxt = S_FULL;
        else if (pop && !push && cnt == ONE)        state_nxt = S_EMPTY;
      end
      S_FULL:    if (pop) state_nxt = S_PARTIAL;
      default:   state_nxt = S_EMPTY;
    endcase
  end

  // Handshakes use only the registered flags, so there is no combinational bypass.
  always_comb begin
    push        = if_write & if_write_ce & if_full_n;
    pop         = if_read & if_read_ce & if_empty_n;
    sr_we       = push & ~reset;
    cnt_nxt     = cnt;
    if (push && !pop)      cnt_nxt = cnt + ONE;
    else if (pop && !push) cnt_nxt = cnt - ONE;
    empty_n_nxt = (state_nxt != S_EMPTY);
    full_n_nxt  = (state_nxt != S_FULL);
    sr_addr_nxt = (cnt_nxt == '0) ? '0 : ADDR_WIDTH'(cnt_nxt - ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
      sr_addr    <= '0;
    end else begin
      cnt        <= cnt_nxt;
      if_empty_n <= empty_n_nxt;
      if_full_n  <= full_n_nxt;
      sr_addr    <= sr_addr_nxt;
    end
  end

`ifdef START_FIFO_STATUS_EN
  assign usedw = cnt;

  always_ff @(posedge clk) begin
    if (reset)
      err_sticky <= 1'b0;
    else if ((if_write & if_write_ce & ~if_full_n) | (if_read & if_read_ce & ~if_empty_n))
      err_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Randomized and directed bench for linear_layer_start_fifo_ctrl against a queue-based token model.
module tb_linear_layer_start_fifo_ctrl;
  localparam int AW = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic          if_full_n, if_empty_n, sr_we;
  logic [AW-1:0] sr_addr;
`ifdef START_FIFO_STATUS_EN
  logic [AW:0]   usedw;
  logic          err_sticky;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] din;
  logic [7:0] tb_sr [D];
  logic [7:0] q [$];
  bit         exp_push, exp_pop, exp_err;

  always #5 clk = ~clk;

  linear_layer_start_fifo_ctrl #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_empty_n(if_empty_n),
    .sr_we(sr_we),
`ifdef START_FIFO_STATUS_EN
    .usedw(usedw), .err_sticky(err_sticky),
`endif
    .sr_addr(sr_addr)
  );

  // Companion shift-register storage: index 0 holds the newest token.
  always_ff @(posedge clk) begin
    if (sr_we) begin
      for (int i = D - 1; i > 0; i--) tb_sr[i] <= tb_sr[i-1];
      tb_sr[0] <= din;
    end
  end

  task automatic set_in(input bit w, input bit wce, input bit r, input bit rce, input bit rst);
    @(negedge clk);
    if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce; reset = rst;
    din = 8'($urandom);
    exp_push = !rst && w && wce && (q.size() < D);
    exp_pop  = !rst && r && rce && (q.size() > 0);
    #1;
  endtask

  task automatic advance();
    if (reset) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      if ((if_write && if_write_ce && q.size() == D) || (if_read && if_read_ce && q.size() == 0))
        exp_err = 1'b1;
      if (exp_pop)  void'(q.pop_front());
      if (exp_push) q.push_back(din);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (sr_we !== 1'b0) begin errors++; $display("FAIL reset_sr_we got=%b want=0", sr_we); end
    advance();
    for (int c = 0; c < 5; c++) begin
      set_in(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0);
      checks++; if (sr_we !== 1'b0) begin errors++; $display("FAIL idle_sr_we got=%b want=0", sr_we); end
      advance();
      checks++;
      if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || sr_addr !== '0) begin
        errors++; $display("FAIL idle_flags empty_n=%b full_n=%b addr=%0d want 0/1/0", if_empty_n, if_full_n, sr_addr);
      end
    end
  endtask

  task automatic test_fill();
    logic [AW-1:0] ea;
    for (int i = 0; i < D; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (sr_we !== 1'b1) begin errors++; $display("FAIL fill_sr_we got=%b want=1", sr_we); end
      advance();
      ea = AW'(i);
      checks++;
      if (sr_addr !== ea || if_empty_n !== 1'b1 || if_full_n !== (i < D - 1)) begin
        errors++; $display("FAIL fill_state addr=%0d empty_n=%b full_n=%b want addr=%0d", sr_addr, if_empty_n, if_full_n, ea);
      end
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (sr_we !== 1'b0) begin errors++; $display("FAIL full_push_sr_we got=%b want=0", sr_we); end
    advance();
    checks++;
    if (if_full_n !== 1'b0 || sr_addr !== AW'(D - 1)) begin
      errors++; $display("FAIL full_hold full_n=%b addr=%0d want 0/%0d", if_full_n, sr_addr, D - 1);
    end
`ifdef START_FIFO_STATUS_EN
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL full_err got=%b want=1", err_sticky); end
`endif
  endtask

  task automatic test_full_push_pop();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (sr_we !== 1'b0) begin errors++; $display("FAIL fpp_sr_we got=%b want=0", sr_we); end
    checks++; if (tb_sr[sr_addr] !== q[0]) begin errors++; $display("FAIL fpp_data got=%h want=%h", tb_sr[sr_addr], q[0]); end
    advance();
    checks++;
    if (if_full_n !== 1'b1 || if_empty_n !== 1'b1 || sr_addr !== AW'(D - 2)) begin
      errors++; $display("FAIL fpp_state full_n=%b empty_n=%b addr=%0d want 1/1/%0d", if_full_n, if_empty_n, sr_addr, D - 2);
    end
    for (int i = 0; i < D - 1; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (tb_sr[sr_addr] !== q[0]) begin errors++; $display("FAIL drain_data got=%h want=%h", tb_sr[sr_addr], q[0]); end
      advance();
    end
    checks++;
    if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || sr_addr !== '0) begin
      errors++; $display("FAIL drain_empty empty_n=%b full_n=%b addr=%0d want 0/1/0", if_empty_n, if_full_n, sr_addr);
    end
  endtask

  task automatic test_empty_push_pop();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (sr_we !== 1'b1) begin errors++; $display("FAIL epp_sr_we got=%b want=1", sr_we); end
    advance();
    checks++;
    if (if_empty_n !== 1'b1 || sr_addr !== '0 || if_full_n !== 1'b1) begin
      errors++; $display("FAIL epp_state empty_n=%b addr=%0d full_n=%b want 1/0/1", if_empty_n, sr_addr, if_full_n);
    end
`ifdef START_FIFO_STATUS_EN
    checks++; if (usedw !== 3'd1) begin errors++; $display("FAIL epp_usedw got=%0d want=1", usedw); end
`endif
  endtask

  task automatic test_partial_push_pop();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (sr_we !== 1'b1) begin errors++; $display("FAIL ppp_sr_we got=%b want=1", sr_we); end
    checks++; if (tb_sr[sr_addr] !== q[0]) begin errors++; $display("FAIL ppp_data got=%h want=%h", tb_sr[sr_addr], q[0]); end
    advance();
    checks++; if (sr_addr !== AW'(1)) begin errors++; $display("FAIL ppp_addr got=%0d want=1", sr_addr); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (tb_sr[sr_addr] !== q[0]) begin errors++; $display("FAIL ppp_next got=%h want=%h", tb_sr[sr_addr], q[0]); end
    advance();
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    bit            rst;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) != 0), rst);
      checks++; if (sr_we !== exp_push) begin errors++; $display("FAIL rnd_sr_we cyc=%0d got=%b want=%b", c, sr_we, exp_push); end
      if (exp_pop) begin
        checks++;
        if (tb_sr[sr_addr] !== q[0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", c, tb_sr[sr_addr], q[0]); end
      end
      advance();
      ea = (q.size() == 0) ? '0 : AW'(q.size() - 1);
      checks++;
      if (if_empty_n !== (q.size() > 0) || if_full_n !== (q.size() < D) || sr_addr !== ea) begin
        errors++; $display("FAIL rnd_flags cyc=%0d empty_n=%b full_n=%b addr=%0d want occupancy=%0d", c, if_empty_n, if_full_n, sr_addr, q.size());
      end
`ifdef START_FIFO_STATUS_EN
      checks++;
      if (usedw !== (AW+1)'(q.size()) || err_sticky !== exp_err) begin
        errors++; $display("FAIL rnd_status cyc=%0d usedw=%0d err=%b want %0d/%b", c, usedw, err_sticky, q.size(), exp_err);
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      advance();
    end
    checks++; if (sr_addr !== AW'(2)) begin errors++; $display("FAIL mr_pre addr=%0d want=2", sr_addr); end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (sr_we !== 1'b0) begin errors++; $display("FAIL mr_sr_we got=%b want=0", sr_we); end
    advance();
    checks++;
    if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || sr_addr !== '0) begin
      errors++; $display("FAIL mr_state empty_n=%b full_n=%b addr=%0d want 0/1/0", if_empty_n, if_full_n, sr_addr);
    end
`ifdef START_FIFO_STATUS_EN
    checks++;
    if (usedw !== '0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL mr_status usedw=%0d err=%b want 0/0", usedw, err_sticky);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0; din = '0;
    exp_err = 1'b0;
    test_reset();
    test_fill();
    test_full_push_pop();
    test_empty_push_pop();
    test_partial_push_pop();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/linear_layer_start_fifo_ctrl.md
LINEAR_LAYER_START_FIFO_CTRL -- requirements
Module: linear_layer_start_fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 1, width of the shift-register address bus; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-002 Parameter DEPTH, default 2, number of start tokens held; legal range 2..2**ADDR_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_write_ce  input  1  producer write clock-enable; a push needs it high.
REQ-006 if_write  input  1  producer push request.
REQ-007 if_full_n  output  1  high when a push can be accepted.
REQ-008 if_read_ce  input  1  consumer read clock-enable; a pop needs it high.
REQ-009 if_read  input  1  consumer pop request.
REQ-010 if_empty_n  output  1  high when a token is available at the shift-register output.
REQ-011 sr_we  output  1  write/shift enable to the companion shift-register storage.
REQ-012 sr_addr  output  ADDR_WIDTH  read tap select to the companion shift-register storage.

Function
REQ-013 push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n; both SHALL be evaluated from registered flags only.
REQ-014 sr_we SHALL equal push combinationally; the storage shifts and loads on that same edge.
REQ-015 Occupancy register cnt (0..DEPTH) SHALL update: push only -> cnt+1; pop only -> cnt-1; both or neither -> unchanged.
REQ-016 sr_addr SHALL be registered and equal cnt-1 when cnt>0, and 0 when cnt=0.
REQ-017 State machine SHALL have three states: EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH).
REQ-018 Transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push-only reaching DEPTH; PARTIAL->EMPTY on pop-only reaching 0; FULL->PARTIAL on pop; all others hold.
REQ-019 if_empty_n SHALL be registered, high exactly in PARTIAL and FULL; if_full_n SHALL be registered, high exactly in EMPTY and PARTIAL.
REQ-020 Latency: a token pushed at edge N SHALL be visible (if_empty_n=1, sr_addr pointing to it) after edge N, i.e. poppable in cycle N+1; no bypass in EMPTY.
REQ-021 In FULL, a push request SHALL be ignored (no sr_we); a simultaneous pop SHALL still be taken, leaving cnt=DEPTH-1.
REQ-022 In EMPTY, a pop request SHALL be ignored and cnt SHALL not underflow; a simultaneous push SHALL be taken.
REQ-023 Simultaneous push and pop in PARTIAL SHALL shift storage, keep cnt and sr_addr unchanged, and deliver the next-oldest token.
REQ-024 Tokens SHALL be delivered in strict FIFO order.

Reset
REQ-025 While reset is high at an edge: cnt=0, state EMPTY, if_empty_n=0, if_full_n=1, sr_addr=0; reset SHALL override any concurrent push/pop.
REQ-026 sr_we SHALL be 0 whenever reset is high, so no storage write occurs during reset.
REQ-027 Reset asserted mid-operation SHALL discard all held tokens; storage contents are don't-care afterwards.

Configuration
REQ-028 With macro START_FIFO_STATUS_EN defined, the block SHALL add output usedw (ADDR_WIDTH+1 bits, registered cnt, reset 0) and output err_sticky (1 bit, reset 0), set when push is requested in FULL or pop requested in EMPTY (ce high), cleared only by reset.
REQ-029 Without START_FIFO_STATUS_EN, usedw and err_sticky SHALL not exist and behaviour is otherwise identical.

Verification
REQ-030 Reset then idle 5 cycles -> if_empty_n=0, if_full_n=1, sr_addr=0, sr_we=0 throughout.
REQ-031 DEPTH=2: push at cycles 1,2 -> if_full_n=0 after cycle 2, sr_addr=1; third push with ce=1 -> sr_we=0, err_sticky=1 (macro on).
REQ-032 DEPTH=4, cnt=2: push and pop same cycle -> cnt stays 2, sr_addr stays 1, popped token is oldest.
REQ-033 FULL with push+pop same cycle -> push dropped, cnt=DEPTH-1, if_full_n=1 next cycle.
REQ-034 EMPTY with push+pop same cycle -> pop ignored, cnt=1, if_empty_n=1 next cycle, sr_addr=0.
REQ-035 Reset pulse with cnt=3, DEPTH=4 -> next cycle cnt=0, if_empty_n=0, if_full_n=1, usedw=0.
